// File: rtl/arm_mem_pkg.sv
// Shared memory-map constants, flash range helper and fetch FSM encoding.
package arm_mem_pkg;

    localparam logic [31:0] ROM_BASE    = 32'h0800_0000;
    localparam logic [31:0] ROM_LAST    = 32'h080F_FFFF;
    localparam logic [11:0] ROM_BASE_HI = ROM_BASE[31:20];

    // True when a byte address falls inside the on-chip flash window.
    function automatic logic in_rom(input logic [31:0] addr);
        return (addr >= ROM_BASE) && (addr <= ROM_LAST);
    endfunction

    typedef enum logic [0:0] {
        StFetch,
        StFault
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding prefetched {instruction, pc} entries.
// Flush beats push; head reads as zero while the queue is empty.
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Guard against popping empty or pushing into a queue with no room left.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr_q] <= push_data;
    end

    // Head output, forced to zero when nothing is queued.
    always_comb begin
        count = count_q;
        head  = (count_q != '0) ? mem[rd_ptr_q] : '0;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-word-per-cycle flash reads, prefetch queue,
// valid/ready delivery to decode, redirect with epoch-based response squashing.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0800_0000,
    parameter logic [11:0] ROM_BASE_HI = 12'h080,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_address,
    output logic        rom_write_enable,
    output logic [31:0] rom_data_in,
    input  logic [31:0] rom_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    import arm_mem_pkg::*;

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, req_pc_q;
    logic             epoch_q, req_epoch_q, inflight_q;
    logic [CNT_W-1:0] q_count;
    logic [63:0]      q_head;
    logic [CNT_W:0]   occupancy;
    logic             pop, issue, resp_push, pc_bad, has_credit;

    // Credit check: entries that will be held after this cycle's pop, plus the outstanding read.
    always_comb begin
        pop        = instr_valid && instr_ready;
        occupancy  = {1'b0, q_count} - (CNT_W + 1)'(pop) + (CNT_W + 1)'(inflight_q);
        has_credit = occupancy < (CNT_W + 1)'(QUEUE_DEPTH);
        pc_bad     = (pc_q[31:20] != ROM_BASE_HI) || (pc_q[1:0] != 2'b00);
        resp_push  = inflight_q && (req_epoch_q == epoch_q);
    end

    // FSM next state and issue decision; redirect always returns to fetching.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            StFetch: begin
                if (pc_bad) begin
                    state_d = StFault;
                end else if (has_credit) begin
                    issue = 1'b1;
                end
            end
            StFault: state_d = StFault;
            default: state_d = StFetch;
        endcase
        if (redirect_valid) state_d = StFetch;
    end

    // PC, epoch and in-flight request bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            epoch_q     <= 1'b0;
            inflight_q  <= 1'b0;
            req_pc_q    <= '0;
            req_epoch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                req_pc_q    <= pc_q;
                req_epoch_q <= epoch_q;
            end
            // A request issued alongside a redirect carries the old epoch and is dropped.
            if (redirect_valid) begin
                pc_q    <= redirect_pc;
                epoch_q <= ~epoch_q;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    fetch_queue #(
        .WIDTH (64),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (resp_push),
        .push_data ({rom_data_out, req_pc_q}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (q_count),
        .head      (q_head)
    );

    // Flash port and decode-side outputs.
    always_comb begin
        rom_address      = {ROM_BASE_HI, 2'b00, pc_q[19:2]};
        rom_write_enable = 1'b0;
        rom_data_in      = '0;
        instr_valid      = (q_count != '0);
        instr_data       = q_head[63:32];
        instr_pc         = q_head[31:0];
        fetch_fault      = (state_q == StFault);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle flash model where word[n] = n.
module tb_instr_fetch;

    localparam logic [31:0] BASE = 32'h0800_0000;

    logic        clock, reset;
    logic [31:0] rom_address, rom_data_in, rom_data_out;
    logic        rom_write_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready, fetch_fault;
    logic [31:0] instr_data, instr_pc;

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clock            (clock),
        .reset            (reset),
        .rom_address      (rom_address),
        .rom_write_enable (rom_write_enable),
        .rom_data_in      (rom_data_in),
        .rom_data_out     (rom_data_out),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .fetch_fault      (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous flash: returns the word index of the sampled address next cycle.
    always @(posedge clock) rom_data_out <= {14'd0, rom_address[17:0]};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        logic [31:0] word;
        word = {14'd0, pc[19:2]};
        check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check_eq({tag, "_pc"}, instr_pc, pc);
        check_eq({tag, "_data"}, instr_data, word);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    // A push that finds the queue full with no pop would lose a word.
    always @(negedge clock) begin
        if (!reset)
            check_eq("push_full", {31'd0, dut.resp_push && !dut.pop && (dut.q_count == 2'd2)},
                     32'd0);
    end

    initial begin
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) step();
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check_eq("rst_data", instr_data, 32'd0);
        check_eq("rst_pc", instr_pc, 32'd0);
        check_eq("rom_we", {31'd0, rom_write_enable}, 32'd0);
        check_eq("rom_din", rom_data_in, 32'd0);

        // 1: streaming from reset release
        reset = 1'b0;
        step();
        check_eq("t1_lat1", {31'd0, instr_valid}, 32'd0);
        instr_ready = 1'b1;
        step();
        expect_head("t1_first", BASE);
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_head("t1_stream", BASE + 32'(4 * i));
        end

        // 2: back-pressure holds the head; release loses nothing
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_head("t2_hold", BASE + 32'd20);
        end
        instr_ready = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            step();
            expect_head("t2_drain", BASE + 32'(4 * i));
        end

        // 3: redirect with a response in flight
        redirect(32'h0800_0100);
        check_eq("t3_flush", {31'd0, instr_valid}, 32'd0);
        step();
        check_eq("t3_stale", {31'd0, instr_valid}, 32'd0);
        step();
        expect_head("t3_tgt", 32'h0800_0100);
        step();
        expect_head("t3_next", 32'h0800_0104);

        // 4: redirect outside flash
        redirect(32'h2000_0000);
        check_eq("t4_fault0", {31'd0, fetch_fault}, 32'd0);
        check_eq("t4_valid0", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t4_fault", {31'd0, fetch_fault}, 32'd1);
            check_eq("t4_valid", {31'd0, instr_valid}, 32'd0);
        end
        redirect(BASE);
        check_eq("t4_clear", {31'd0, fetch_fault}, 32'd0);
        step();
        check_eq("t4_lat", {31'd0, instr_valid}, 32'd0);
        step();
        expect_head("t4_resume", BASE);

        // 5a: misaligned redirect
        redirect(32'h0800_0002);
        check_eq("t5a_fault0", {31'd0, fetch_fault}, 32'd0);
        step();
        check_eq("t5a_fault", {31'd0, fetch_fault}, 32'd1);
        check_eq("t5a_valid", {31'd0, instr_valid}, 32'd0);

        // 5b: running off the end of flash
        redirect(32'h080F_FFF8);
        check_eq("t5b_clear", {31'd0, fetch_fault}, 32'd0);
        step();
        check_eq("t5b_lat", {31'd0, instr_valid}, 32'd0);
        step();
        expect_head("t5b_w0", 32'h080F_FFF8);
        check_eq("t5b_nofault", {31'd0, fetch_fault}, 32'd0);
        step();
        expect_head("t5b_last", 32'h080F_FFFC);
        check_eq("t5b_fault", {31'd0, fetch_fault}, 32'd1);
        step();
        check_eq("t5b_empty", {31'd0, instr_valid}, 32'd0);
        check_eq("t5b_hold", {31'd0, fetch_fault}, 32'd1);

        // 6: reset with a full queue
        redirect(BASE);
        step();
        step();
        expect_head("t6_pre", BASE);
        instr_ready = 1'b0;
        step();
        step();
        expect_head("t6_full", BASE);
        reset = 1'b1;
        step();
        reset = 1'b0;
        instr_ready = 1'b1;
        check_eq("t6_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t6_fault", {31'd0, fetch_fault}, 32'd0);
        check_eq("t6_data", instr_data, 32'd0);
        step();
        check_eq("t6_lat", {31'd0, instr_valid}, 32'd0);
        step();
        expect_head("t6_restart", BASE);
        step();
        expect_head("t6_next", BASE + 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
